// File: rtl/lc3_mport_mem_pkg.sv
// Shared types and default sizes for the LC3 multi-channel memory model.
// Holds the per-channel FSM state enum and the default parameter values.
package lc3_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ARB, DONE} mem_ch_state_t;

  localparam int NUM_CH_DEF       = 2;
  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 16;
  localparam int MEM_AW_DEF       = 16;
  localparam int WAIT_W_DEF       = 4;
  localparam int STALL_THRESH_DEF = 1000;

endpackage

// File: rtl/lc3_mport_mem_if.sv
// Request/response bundle for lc3_mport_mem, one slot per channel.
//   master: drives cfg_wait/req/rd/addr/wdata, observes rdata/complete/stall_err/busy
//   slave : the memory model side
interface lc3_mport_mem_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WAIT_W = 4
);
  logic [NUM_CH-1:0][WAIT_W-1:0] cfg_wait;
  logic [NUM_CH-1:0]             req;
  logic [NUM_CH-1:0]             rd;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr;
  logic [NUM_CH-1:0][DATA_W-1:0] wdata;
  logic [NUM_CH-1:0][DATA_W-1:0] rdata;
  logic [NUM_CH-1:0]             complete;
  logic [NUM_CH-1:0]             stall_err;
  logic                          busy;

  modport master (output cfg_wait, req, rd, addr, wdata,
                  input  rdata, complete, stall_err, busy);
  modport slave  (input  cfg_wait, req, rd, addr, wdata,
                  output rdata, complete, stall_err, busy);
endinterface

// File: rtl/lc3_rr_arbiter.sv
// Round-robin arbiter for the single array port.
//   clock, reset : rising edge, synchronous active-high
//   req[N]       : channels waiting for the array
//   gnt[N]       : one-hot grant, combinational from req and the pointer
// Search starts at ptr; after a grant to i the pointer moves to (i+1)%N.
module lc3_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr, nxt, idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    nxt   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        nxt      = PW'((int'(idx) + 1) % N);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)      ptr <= '0;
    else if (|req)  ptr <= nxt;
  end
endmodule

// File: rtl/lc3_mport_mem.sv
// Multi-channel memory model for the LC3 bench: NUM_CH request channels share
// one array with a single registered read/write port.
//   clock, reset : rising edge, synchronous active-high (array contents kept)
//   bus (slave)  : per-channel cfg_wait/req/rd/addr/wdata in,
//                  rdata/complete/stall_err out, busy = any channel not IDLE
// Each channel runs IDLE -> WAIT -> ARB -> DONE; wait states come from cfg_wait
// at capture, ARB competes round-robin for the port, DONE pulses complete.
module lc3_mport_mem
  import lc3_mem_pkg::*;
#(
  parameter int    NUM_CH       = NUM_CH_DEF,
  parameter int    ADDR_W       = ADDR_W_DEF,
  parameter int    DATA_W       = DATA_W_DEF,
  parameter int    MEM_AW       = MEM_AW_DEF,
  parameter int    WAIT_W       = WAIT_W_DEF,
  parameter int    STALL_THRESH = STALL_THRESH_DEF,
  parameter string INIT_FILE    = ""
) (
  input  logic            clock,
  input  logic            reset,
  lc3_mport_mem_if.slave  bus
);
  localparam int WD_W = $clog2(STALL_THRESH + 1);

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  logic [NUM_CH-1:0]             arb_req, gnt, ch_rd, ch_busy;
  logic [NUM_CH-1:0][MEM_AW-1:0] ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata;

  logic              g_any, g_rd;
  logic [MEM_AW-1:0] g_idx;
  logic [DATA_W-1:0] g_wdata, mem_rd;

  lc3_rr_arbiter #(.N(NUM_CH)) u_arb (
    .clock (clock),
    .reset (reset),
    .req   (arb_req),
    .gnt   (gnt)
  );

  // Steer the granted channel's captured request onto the array port.
  always_comb begin
    g_idx   = ch_addr[0];
    g_rd    = ch_rd[0];
    g_wdata = ch_wdata[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        g_idx   = ch_addr[i];
        g_rd    = ch_rd[i];
        g_wdata = ch_wdata[i];
      end
    end
  end

  assign g_any  = |gnt;
  assign mem_rd = mem[g_idx];

  // A write granted on a reset edge is dropped.
  always_ff @(posedge clock) begin
    if (!reset && g_any && !g_rd) mem[g_idx] <= g_wdata;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mem_ch_state_t     st;
    logic [WAIT_W-1:0] cnt;
    logic [WD_W-1:0]   wd;
    logic              rd_q, cmp_q, stall_q;
    logic [MEM_AW-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    // Dropping req while in ARB withdraws the bid before it can be granted.
    assign arb_req[i]       = (st == ARB) && bus.req[i];
    assign ch_busy[i]       = (st != IDLE);
    assign ch_rd[i]         = rd_q;
    assign ch_addr[i]       = addr_q;
    assign ch_wdata[i]      = wdata_q;
    assign bus.rdata[i]     = rdata_q;
    assign bus.complete[i]  = cmp_q;
    assign bus.stall_err[i] = stall_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        st      <= IDLE;
        cnt     <= '0;
        wd      <= '0;
        rd_q    <= 1'b1;
        addr_q  <= '0;
        wdata_q <= '0;
        rdata_q <= '0;
        cmp_q   <= 1'b0;
        stall_q <= 1'b0;
      end else begin
        cmp_q <= 1'b0;

        // Watchdog: counts pending cycles, saturates, flag is sticky.
        if (!bus.req[i] || st == DONE) wd <= '0;
        else if (wd != WD_W'(STALL_THRESH)) wd <= wd + 1'b1;
        if (bus.req[i] && st != DONE && wd >= WD_W'(STALL_THRESH - 1)) stall_q <= 1'b1;

        case (st)
          IDLE: if (bus.req[i]) begin
            rd_q    <= bus.rd[i];
            addr_q  <= bus.addr[i][MEM_AW-1:0];
            wdata_q <= bus.wdata[i];
            cnt     <= bus.cfg_wait[i];
            st      <= (bus.cfg_wait[i] == '0) ? ARB : WAIT;
          end
          WAIT: begin
            if (!bus.req[i])    st <= IDLE;
            else if (cnt == 1)  st <= ARB;
            else                cnt <= cnt - 1'b1;
          end
          ARB: begin
            if (!bus.req[i]) st <= IDLE;
            else if (gnt[i]) begin
              st    <= DONE;
              cmp_q <= 1'b1;
              if (rd_q) rdata_q <= mem_rd;
            end
          end
          DONE:    st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = |ch_busy;
endmodule
